// File: rtl/pipe_hazard_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipe_hazard_reg pipeline register.
//   state_t                  : control state of the hazard register (RUN, SQUASH)
//   OP1_LW/OP1_BCOND/OP1_JAL : primary opcode values of the instructions that
//                              create load-use hazards or redirects
//   DEFAULT_*                : default parameter values for the block
//   sat_inc32                : saturating 32-bit increment for statistics
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  localparam logic [6:0] OP1_LW    = 7'b0000011;
  localparam logic [6:0] OP1_BCOND = 7'b1100011;
  localparam logic [6:0] OP1_JAL   = 7'b1101111;

  localparam int DEFAULT_PAYLOAD_W        = 96;
  localparam int DEFAULT_REG_IDX_W        = 4;
  localparam int DEFAULT_REDIRECT_BUBBLES = 1;
  localparam int DEFAULT_CNT_W            = 3;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_reg_if
// Bundles the decode-side inputs and the latched-stage outputs of the
// pipeline hazard register.
//   master modport : decode/execute side plus the consumer of the latched stage
//                    (drives in_*, observes out_*, pc_hold, flush_dec)
//   slave modport  : the pipe_hazard_reg itself
// Parameters:
//   PAYLOAD_W : width of the opaque payload
//   REG_IDX_W : register index width
// ---------------------------------------------------------------------------
interface pipe_hazard_reg_if
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = DEFAULT_PAYLOAD_W,
  parameter int REG_IDX_W = DEFAULT_REG_IDX_W
);

  logic                 in_valid;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 in_wr_en;
  logic [REG_IDX_W-1:0] in_dst;
  logic [REG_IDX_W-1:0] in_src1;
  logic [REG_IDX_W-1:0] in_src2;
  logic                 in_uses_src2;
  logic                 in_is_load;
  logic                 in_redirect;

  logic                 out_valid;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 out_wr_en;
  logic [REG_IDX_W-1:0] out_dst;
  logic                 out_is_load;
  logic                 pc_hold;
  logic                 flush_dec;

  modport master (
    output in_valid, in_payload, in_wr_en, in_dst, in_src1, in_src2,
           in_uses_src2, in_is_load, in_redirect,
    input  out_valid, out_payload, out_wr_en, out_dst, out_is_load,
           pc_hold, flush_dec
  );

  modport slave (
    input  in_valid, in_payload, in_wr_en, in_dst, in_src1, in_src2,
           in_uses_src2, in_is_load, in_redirect,
    output out_valid, out_payload, out_wr_en, out_dst, out_is_load,
           pc_hold, flush_dec
  );

endinterface

// File: rtl/pipe_hazard_reg_bubble_counter.sv
// ---------------------------------------------------------------------------
// bubble_counter
// Loadable down-counter that tracks how many squash bubbles remain after a
// redirect.
// Ports:
//   clk, reset : pipeline clock, asynchronous active-high reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, stopping at zero
//   is_zero    : count == 0
//   is_one     : count == 1 (last bubble of the squash window)
// ---------------------------------------------------------------------------
module bubble_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_zero,
  output logic             is_one
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; decrement never wraps below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == CNT_W'(1));

endmodule

// File: rtl/pipe_hazard_reg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_reg
// Pipeline register between decode/execute and memory/writeback. Latches a
// payload plus writeback control, stalls one cycle on a load-use hazard and
// squashes REDIRECT_BUBBLES wrong-path decode slots after a taken branch/JAL.
// Ports:
//   clk         : pipeline clock
//   reset       : asynchronous, active-high
//   bus         : pipe_hazard_reg_if.slave (decode inputs, latched outputs,
//                 combinational pc_hold / flush_dec)
//   stat_stall  : (PIPE_STATS_EN only) saturating count of load-use stall cycles
//   stat_squash : (PIPE_STATS_EN only) saturating count of squash cycles
// Parameters:
//   PAYLOAD_W, REG_IDX_W : must match the connected interface instance
//   REDIRECT_BUBBLES     : squashed cycles after a redirect, 0..7
//   CNT_W                : bubble counter width, must hold REDIRECT_BUBBLES
// Optional feature macro: PIPE_STATS_EN
// ---------------------------------------------------------------------------
module pipe_hazard_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W        = DEFAULT_PAYLOAD_W,
  parameter int REG_IDX_W        = DEFAULT_REG_IDX_W,
  parameter int REDIRECT_BUBBLES = DEFAULT_REDIRECT_BUBBLES,
  parameter int CNT_W            = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_reg_if.slave bus
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0]      stat_stall,
  output logic [31:0]      stat_squash
`endif
);

  state_t               state;
  state_t               state_next;

  logic                 valid_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 wr_en_q;
  logic [REG_IDX_W-1:0] dst_q;
  logic                 is_load_q;

  logic                 haz;
  logic                 in_squash;
  logic                 capture;
  logic                 load_fields;
  logic                 load_bubble;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_is_zero;
  logic                 cnt_is_one;
  logic                 hold_c;
  logic                 flush_c;

  // A load in the latched stage feeds a register the decode instruction
  // reads; src2 only counts when it is really read (not an immediate).
  assign haz = valid_q & is_load_q & bus.in_valid &
               ((bus.in_src1 == dst_q) | (bus.in_uses_src2 & (bus.in_src2 == dst_q)));

  assign in_squash = (state == SQUASH);
  assign capture   = bus.in_valid & ~haz & ~in_squash;

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. A hazard wins over a redirect: the
  // hazarded branch stalls and redirects when it is presented again.
  always_comb begin
    state_next  = state;
    hold_c      = 1'b0;
    flush_c     = 1'b0;
    load_fields = 1'b0;
    load_bubble = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state)
      RUN: begin
        if (haz) begin
          hold_c      = 1'b1;
          load_bubble = 1'b1;
        end else begin
          load_fields = 1'b1;
          if (capture && bus.in_redirect && (REDIRECT_BUBBLES > 0)) begin
            cnt_load   = 1'b1;
            state_next = SQUASH;
          end
        end
      end
      SQUASH: begin
        flush_c     = 1'b1;
        load_bubble = 1'b1;
        cnt_dec     = 1'b1;
        // is_zero only guards against a window that should never occur.
        if (cnt_is_one || cnt_is_zero) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign bus.pc_hold   = hold_c;
  assign bus.flush_dec = flush_c;

  // Remaining squash slots after a redirect.
  bubble_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(REDIRECT_BUBBLES)),
    .dec      (cnt_dec),
    .is_zero  (cnt_is_zero),
    .is_one   (cnt_is_one)
  );

  // Latched stage. Write enable and load flag are qualified with valid so a
  // bubble can never write the register file; a bubble keeps the old payload
  // and destination to avoid needless toggling of the wide payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      wr_en_q   <= 1'b0;
      dst_q     <= '0;
      is_load_q <= 1'b0;
    end else if (load_fields) begin
      valid_q   <= bus.in_valid;
      payload_q <= bus.in_payload;
      wr_en_q   <= bus.in_wr_en & bus.in_valid;
      dst_q     <= bus.in_dst;
      is_load_q <= bus.in_is_load & bus.in_valid;
    end else if (load_bubble) begin
      valid_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      is_load_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_payload = payload_q;
  assign bus.out_wr_en   = wr_en_q;
  assign bus.out_dst     = dst_q;
  assign bus.out_is_load = is_load_q;

`ifdef PIPE_STATS_EN
  // Statistics: stall cycles are hazard cycles seen in RUN; squash cycles are
  // every cycle spent in SQUASH. Both saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_stall  <= '0;
      stat_squash <= '0;
    end else begin
      if (hold_c) begin
        stat_stall <= sat_inc32(stat_stall);
      end
      if (flush_c) begin
        stat_squash <= sat_inc32(stat_squash);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_reg
// Self-checking bench for pipe_hazard_reg with REDIRECT_BUBBLES=2. Directed
// sequences cover reset, pass-through, load-use stalls, src2 gating and
// redirects; a random phase follows. A behavioural model tracks the latched
// instruction and the number of squash slots still owed.
// Optional feature macro: PIPE_STATS_EN
// ---------------------------------------------------------------------------
module tb_pipe_hazard_reg;
  import pipe_pkg::*;

  localparam int PW = 96;
  localparam int RW = 4;
  localparam int RB = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_hazard_reg_if #(.PAYLOAD_W(PW), .REG_IDX_W(RW)) bus ();

`ifdef PIPE_STATS_EN
  logic [31:0] stat_stall;
  logic [31:0] stat_squash;
`endif

  pipe_hazard_reg #(
    .PAYLOAD_W       (PW),
    .REG_IDX_W       (RW),
    .REDIRECT_BUBBLES(RB),
    .CNT_W           (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef PIPE_STATS_EN
    ,
    .stat_stall (stat_stall),
    .stat_squash(stat_squash)
`endif
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: the instruction sitting in the latched stage and how
  // many decode slots are still owed as squash after a redirect.
  bit            m_valid;
  logic [PW-1:0] m_payload;
  bit            m_wr_en;
  logic [RW-1:0] m_dst;
  bit            m_is_load;
  int            m_squash_left;
  longint        m_stalls;
  longint        m_squashes;
  bit            exp_hold;
  bit            exp_flush;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_valid       = 1'b0;
    m_payload     = '0;
    m_wr_en       = 1'b0;
    m_dst         = '0;
    m_is_load     = 1'b0;
    m_squash_left = 0;
    m_stalls      = 0;
    m_squashes    = 0;
  endtask

  task automatic driveIdle();
    bus.in_valid     = 1'b0;
    bus.in_payload   = '0;
    bus.in_wr_en     = 1'b0;
    bus.in_dst       = '0;
    bus.in_src1      = '0;
    bus.in_src2      = '0;
    bus.in_uses_src2 = 1'b0;
    bus.in_is_load   = 1'b0;
    bus.in_redirect  = 1'b0;
  endtask

  // One pipeline cycle: drive decode inputs away from the edge, check the
  // combinational outputs, advance the model across the edge, then check
  // the latched stage.
  task automatic applyStimulus(input bit v, input logic [PW-1:0] p, input bit we,
                               input logic [RW-1:0] d, input logic [RW-1:0] s1,
                               input logic [RW-1:0] s2, input bit u2, input bit ld,
                               input bit rd);
    bit haz;
    @(negedge clk);
    bus.in_valid     = v;
    bus.in_payload   = p;
    bus.in_wr_en     = we;
    bus.in_dst       = d;
    bus.in_src1      = s1;
    bus.in_src2      = s2;
    bus.in_uses_src2 = u2;
    bus.in_is_load   = ld;
    bus.in_redirect  = rd;
    #1;
    haz       = m_valid && m_is_load && v && ((s1 == m_dst) || (u2 && (s2 == m_dst)));
    exp_flush = (m_squash_left > 0);
    exp_hold  = !exp_flush && haz;
    checkOutput("pc_hold", bus.pc_hold, exp_hold);
    checkOutput("flush_dec", bus.flush_dec, exp_flush);
    @(posedge clk);
    if (exp_flush || exp_hold) begin
      m_valid   = 1'b0;
      m_wr_en   = 1'b0;
      m_is_load = 1'b0;
      if (exp_flush) begin
        m_squash_left--;
        m_squashes++;
      end else begin
        m_stalls++;
      end
    end else begin
      m_valid   = v;
      m_payload = p;
      m_wr_en   = we && v;
      m_dst     = d;
      m_is_load = ld && v;
      if (v && rd) m_squash_left = RB;
    end
    #1;
    checkOutput("out_valid", bus.out_valid, m_valid);
    checkOutput("out_wr_en", bus.out_wr_en, m_wr_en);
    checkOutput("out_is_load", bus.out_is_load, m_is_load);
    if (m_valid) begin
      checkOutput("out_payload", bus.out_payload, m_payload);
      checkOutput("out_dst", bus.out_dst, m_dst);
    end
`ifdef PIPE_STATS_EN
    checkOutput("stat_stall", stat_stall, m_stalls[31:0]);
    checkOutput("stat_squash", stat_squash, m_squashes[31:0]);
`endif
  endtask

  // Deassert reset on a falling edge with the decode side idle.
  task automatic releaseReset();
    @(negedge clk);
    driveIdle();
    reset = 1'b0;
    modelReset();
  endtask

  logic [PW-1:0] pay_a5;
  logic [PW-1:0] rp;
  bit            rv, rwe, ru2, rld, rrd;
  logic [RW-1:0] rd_i, rs1, rs2;

  initial begin
    pay_a5 = 96'h0123_4567_89AB_CDEF_0000_00A5;
    driveIdle();
    modelReset();
    reset = 1'b1;
    #2;
    $display("[TB] checking reset values");
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_wr_en", bus.out_wr_en, 1'b0);
    checkOutput("rst_out_is_load", bus.out_is_load, 1'b0);
    checkOutput("rst_out_payload", bus.out_payload, '0);
    checkOutput("rst_out_dst", bus.out_dst, '0);
    checkOutput("rst_pc_hold", bus.pc_hold, 1'b0);
    checkOutput("rst_flush_dec", bus.flush_dec, 1'b0);
    releaseReset();

    $display("[TB] pass-through");
    applyStimulus(1, pay_a5, 1, 4'd3, 4'd0, 4'd0, 0, 0, 0);
    checkOutput("pt_payload", bus.out_payload, pay_a5);
    checkOutput("pt_dst", bus.out_dst, 4'd3);
    checkOutput("pt_valid", bus.out_valid, 1'b1);

    $display("[TB] load-use via src1");
    applyStimulus(1, 96'h11, 1, 4'd5, 4'd0, 4'd0, 0, 1, 0);
    applyStimulus(1, 96'h22, 1, 4'd6, 4'd5, 4'd0, 0, 0, 0);
    checkOutput("lu_bubble", bus.out_valid, 1'b0);
    applyStimulus(1, 96'h22, 1, 4'd6, 4'd5, 4'd0, 0, 0, 0);
    checkOutput("lu_capture_dst", bus.out_dst, 4'd6);

    $display("[TB] load-use src2 gating");
    applyStimulus(1, 96'h33, 1, 4'd5, 4'd0, 4'd0, 0, 1, 0);
    applyStimulus(1, 96'h44, 1, 4'd5, 4'd1, 4'd5, 0, 1, 0);
    checkOutput("src2_gated_no_stall", bus.out_valid, 1'b1);
    applyStimulus(1, 96'h55, 1, 4'd7, 4'd1, 4'd5, 1, 0, 0);
    applyStimulus(1, 96'h55, 1, 4'd7, 4'd1, 4'd5, 1, 0, 0);

    $display("[TB] redirect with ignored redirect during squash");
    applyStimulus(1, 96'h66, 0, 4'd0, 4'd8, 4'd9, 1, 0, 1);
    applyStimulus(1, 96'h77, 1, 4'd1, 4'd2, 4'd3, 0, 0, 1);
    applyStimulus(1, 96'h88, 1, 4'd1, 4'd2, 4'd3, 0, 0, 1);
    applyStimulus(1, 96'h99, 1, 4'd1, 4'd2, 4'd3, 0, 0, 0);

    $display("[TB] hazard plus redirect");
    reset = 1'b1;
    #1;
    releaseReset();
    applyStimulus(1, 96'hAA, 1, 4'd2, 4'd0, 4'd0, 0, 1, 0);
    applyStimulus(1, 96'hBB, 0, 4'd0, 4'd2, 4'd0, 0, 0, 1);
    applyStimulus(1, 96'hBB, 0, 4'd0, 4'd2, 4'd0, 0, 0, 1);
    applyStimulus(1, 96'hCC, 1, 4'd1, 4'd0, 4'd0, 0, 0, 0);
    applyStimulus(1, 96'hDD, 1, 4'd1, 4'd0, 4'd0, 0, 0, 0);
`ifdef PIPE_STATS_EN
    checkOutput("hr_stat_stall", stat_stall, 32'd1);
    checkOutput("hr_stat_squash", stat_squash, 32'(RB));
`endif

    $display("[TB] reset mid-cycle while valid");
    applyStimulus(1, 96'hEE, 1, 4'd4, 4'd0, 4'd0, 0, 1, 0);
    #2;
    bus.in_valid = 1'b1;
    bus.in_src1  = 4'd4;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", bus.out_valid, 1'b0);
    checkOutput("mid_rst_wr_en", bus.out_wr_en, 1'b0);
    checkOutput("mid_rst_pc_hold", bus.pc_hold, 1'b0);
    releaseReset();

    $display("[TB] reset mid-squash");
    applyStimulus(1, 96'hF0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("sq_rst_flush", bus.flush_dec, 1'b0);
    checkOutput("sq_rst_valid", bus.out_valid, 1'b0);
    releaseReset();
    applyStimulus(1, 96'hF1, 1, 4'd3, 4'd0, 4'd0, 0, 0, 0);

    $display("[TB] random phase");
    rv = 0; rp = '0; rwe = 0; rd_i = '0; rs1 = '0; rs2 = '0; ru2 = 0; rld = 0; rrd = 0;
    for (int i = 0; i < 400; i++) begin
      // A stalled decode instruction is re-presented unchanged.
      if (!(exp_hold && !exp_flush) || i == 0) begin
        rv   = ($urandom_range(0, 3) != 0);
        rp   = {$urandom, $urandom, $urandom};
        rwe  = $urandom_range(0, 1) == 1;
        rd_i = RW'($urandom_range(0, 3));
        rs1  = RW'($urandom_range(0, 3));
        rs2  = RW'($urandom_range(0, 3));
        ru2  = $urandom_range(0, 1) == 1;
        rld  = ($urandom_range(0, 2) == 0);
        rrd  = ($urandom_range(0, 4) == 0);
      end
      applyStimulus(rv, rp, rwe, rd_i, rs1, rs2, ru2, rld, rrd);
    end

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_reg.md
Name: pipe_hazard_reg

Overview:
- Parametrised successor to the fixed two-stage pipeline register with branch-only stall.
- Sits between decode/execute and memory/writeback.
- Latches a generic payload plus writeback control, detects load-use hazards, and squashes wrong-path instructions after a redirect.
- Bubble count after a redirect is configurable. Load-use stalls are new behaviour.

Parameters:
- PAYLOAD_W, 96: width of opaque payload (ALU result, store data, next PC).
- REG_IDX_W, 4: register index width.
- REDIRECT_BUBBLES, 1: squashed cycles after a taken branch or JAL; legal 0..7.
- CNT_W, 3: width of bubble counter; must hold REDIRECT_BUBBLES.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  decode-stage instruction present
- in_payload  in  PAYLOAD_W  decode-stage payload
- in_wr_en  in  1  instruction writes the register file
- in_dst  in  REG_IDX_W  destination register
- in_src1  in  REG_IDX_W  source register 1
- in_src2  in  REG_IDX_W  source register 2
- in_uses_src2  in  1  src2 is read (not immediate)
- in_is_load  in  1  instruction is a load
- in_redirect  in  1  taken branch or JAL, resolved this cycle
- out_valid  out  1  latched stage holds a real instruction
- out_payload  out  PAYLOAD_W  latched payload
- out_wr_en  out  1  latched write enable, forced 0 when out_valid=0
- out_dst  out  REG_IDX_W  latched destination
- out_is_load  out  1  latched load flag, forced 0 when out_valid=0
- pc_hold  out  1  combinational; PC must keep its value this cycle
- flush_dec  out  1  combinational; decode instruction is wrong-path and squashed

Behaviour:
- Reset (async, immediate):
  - out_valid, out_wr_en, out_is_load = 0; out_payload and out_dst = 0.
  - State RUN, counter = 0. pc_hold and flush_dec evaluate to 0.
- States: RUN, SQUASH.
- Definitions:
  - haz = out_valid & out_is_load & in_valid & ((in_src1==out_dst) | (in_uses_src2 & in_src2==out_dst)).
  - capture = in_valid & ~haz & ~flush_dec.
- RUN, haz=1:
  - pc_hold=1.
  - Next edge loads a bubble: out_valid=0, out_wr_en=0, out_is_load=0, payload don't-care but held.
  - The decode instruction re-presents next cycle. Exactly one stall cycle per load-use pair.
- RUN, haz=0: next edge loads the input fields, with out_valid=in_valid.
- RUN, capture & in_redirect & REDIRECT_BUBBLES>0:
  - Captures the instruction.
  - Counter loads REDIRECT_BUBBLES; goes to SQUASH.
- SQUASH:
  - flush_dec=1, pc_hold=0.
  - Each edge loads a bubble and decrements the counter; returns to RUN on the edge where counter==1.
  - in_redirect and haz are ignored.
- REDIRECT_BUBBLES=0: SQUASH is never entered.
- Priority: haz over redirect. A hazarded branch stalls first, then redirects on re-presentation.
- Latency: input to output is 1 cycle; pc_hold and flush_dec are 0-cycle combinational.
- Reset mid-SQUASH or mid-stall: abandons immediately and returns to the reset values above.

Optional Feature:
- PIPE_STATS_EN defined:
  - Adds outputs stat_stall (32 b) counting cycles with haz=1 in RUN.
  - Adds stat_squash (32 b) counting SQUASH cycles.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - State enum (RUN, SQUASH).
  - Opcode constants OP1_LW, OP1_BCOND, OP1_JAL.
  - Default REDIRECT_BUBBLES.
- One sub-module, bubble_counter: loadable down-counter with zero/one flags, width CNT_W.

Test Plan:
- Reset: assert reset mid-cycle while out_valid=1 -> out_valid=0, out_wr_en=0 immediately without a clock edge; pc_hold=0.
- Pass-through:
  - Stimulus: in_valid=1, payload=0x...A5, dst=3, wr_en=1, no hazards.
  - Response: next edge out_payload=0x...A5, out_dst=3, out_wr_en=1, out_valid=1.
- Load-use:
  - Stimulus: latched load dst=5, decode src1=5.
  - Response: pc_hold=1 for one cycle; next out_valid=0; the following edge captures the decode instruction; total one bubble.
- Load-use via src2 gating:
  - Stimulus: latched load dst=5, decode src2=5 with in_uses_src2=0.
  - Response: no stall. With in_uses_src2=1 -> one stall cycle.
- Redirect, REDIRECT_BUBBLES=2:
  - Stimulus: taken branch captured.
  - Response: flush_dec=1 for exactly 2 cycles; out_valid=0 for 2 edges; in_redirect pulsed during SQUASH is ignored.
- Hazard plus redirect: latched load dst=2 and decode branch src1=2 with in_redirect=1 -> one stall cycle, then branch captured, then SQUASH; with PIPE_STATS_EN, stat_stall=1 and stat_squash=REDIRECT_BUBBLES.
